seq_pattern_gen: RTL and testbench

- Serial pattern transmitter. Loads a PAT_W-bit word and shifts it MSB-first onto a single bit line, one bit per clk.
- Optional repeat count and inter-frame idle gap.
- Drives the stimulus side of the serial sequence-detector path; the default pattern 8'b01110001 is the one the detector matches.
- The line idles high; reset and gap value is 1.

---
 rtl/seq_pkg.sv | 17 +
 rtl/seq_shift_out.sv | 27 ++
 rtl/seq_pattern_gen.sv | 180 ++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial pattern generator and its detector bench.
package seq_pkg;

   localparam int PAT_W_DEF = 8;
   localparam int REP_W_DEF = 4;
   localparam int GAP_W_DEF = 4;

   localparam logic [7:0] DEFAULT_PAT = 8'b01110001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      PAR  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/seq_shift_out.sv
// Parallel-load, MSB-first shift register; fills with ones so the line idles high.
module seq_shift_out #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         sout
);

   logic [W-1:0] sr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr <= '1;
      end else if (load) begin
         sr <= din;
      end else if (shift) begin
         sr <= {sr[W-2:0], 1'b1};
      end
   end

   assign sout = sr[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: repeat count, inter-frame gap, optional odd-parity bit
// (compile with SEQ_GEN_PARITY_EN to append the parity bit after each frame).
//
// state | meaning
// IDLE  | ready=1, line high; start latches word/rep/gap
// SEND  | shifting pattern bits, bit_cnt counts PAT_W-1 down to 0
// PAR   | parity bit of the current frame (SEQ_GEN_PARITY_EN only)
// GAP   | line high, a_valid=0 for gap_q cycles between frames
module seq_pattern_gen
   import seq_pkg::*;
#(
   parameter int               PAT_W       = PAT_W_DEF,
   parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(seq_pkg::DEFAULT_PAT),
   parameter int               REP_W       = REP_W_DEF,
   parameter int               GAP_W       = GAP_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             use_default,
   input  logic [PAT_W-1:0] pat_in,
   input  logic [REP_W-1:0] rep_in,
   input  logic [GAP_W-1:0] gap_in,
   output logic             ready,
   output logic             a_out,
   output logic             a_valid,
   output logic             done
);

   localparam int BIT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
   localparam logic [BIT_W-1:0] BIT_MSB = BIT_W'(PAT_W - 1);

`ifdef SEQ_GEN_PARITY_EN
   localparam int SH_W = PAT_W + 1;
`else
   localparam int SH_W = PAT_W;
`endif

   seq_state_t       state, state_nxt;
   logic [PAT_W-1:0] word_q, word_nxt;
   logic [REP_W-1:0] rep_cnt, rep_nxt;
   logic [GAP_W-1:0] gap_q, gap_q_nxt;
   logic [GAP_W-1:0] gap_cnt, gap_nxt;
   logic [BIT_W-1:0] bit_cnt, bit_nxt;
   logic             ready_nxt, valid_nxt, done_nxt;
   logic             load, shift, frame_end;
   logic [PAT_W-1:0] word_sel, load_src;
   logic [SH_W-1:0]  frame_word;

   assign word_sel = use_default ? DEFAULT_PAT : pat_in;
   assign load_src = (state == IDLE) ? word_sel : word_q;

`ifdef SEQ_GEN_PARITY_EN
   // Parity rides in the low bit of the shifter so it follows bit 0 naturally.
   assign frame_word = {load_src, ~^load_src};
`else
   assign frame_word = load_src;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         word_q  <= '0;
         rep_cnt <= '0;
         gap_q   <= '0;
         gap_cnt <= '0;
         bit_cnt <= '0;
         ready   <= 1'b1;
         a_valid <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         word_q  <= word_nxt;
         rep_cnt <= rep_nxt;
         gap_q   <= gap_q_nxt;
         gap_cnt <= gap_nxt;
         bit_cnt <= bit_nxt;
         ready   <= ready_nxt;
         a_valid <= valid_nxt;
         done    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      word_nxt  = word_q;
      rep_nxt   = rep_cnt;
      gap_q_nxt = gap_q;
      gap_nxt   = gap_cnt;
      bit_nxt   = bit_cnt;
      ready_nxt = 1'b0;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      frame_end = 1'b0;

      case (state)
         IDLE: begin
            ready_nxt = 1'b1;
            if (start) begin
               word_nxt  = word_sel;
               rep_nxt   = rep_in;
               gap_q_nxt = gap_in;
               load      = 1'b1;
               bit_nxt   = BIT_MSB;
               state_nxt = SEND;
               ready_nxt = 1'b0;
               valid_nxt = 1'b1;
            end
         end
         SEND: begin
            shift = 1'b1;
            if (bit_cnt != '0) begin
               bit_nxt   = bit_cnt - 1'b1;
               valid_nxt = 1'b1;
            end else begin
`ifdef SEQ_GEN_PARITY_EN
               state_nxt = PAR;
               valid_nxt = 1'b1;
`else
               frame_end = 1'b1;
`endif
            end
         end
`ifdef SEQ_GEN_PARITY_EN
         PAR: begin
            shift     = 1'b1;
            frame_end = 1'b1;
         end
`endif
         GAP: begin
            if (gap_cnt == '0) begin
               load      = 1'b1;
               bit_nxt   = BIT_MSB;
               state_nxt = SEND;
               valid_nxt = 1'b1;
            end else begin
               gap_nxt = gap_cnt - 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            ready_nxt = 1'b1;
         end
      endcase

      // End of frame: load wins over the final shift for a back-to-back reload.
      if (frame_end) begin
         if (rep_cnt != '0) begin
            rep_nxt = rep_cnt - 1'b1;
            if (gap_q != '0) begin
               state_nxt = GAP;
               gap_nxt   = gap_q - 1'b1;
            end else begin
               load      = 1'b1;
               bit_nxt   = BIT_MSB;
               state_nxt = SEND;
               valid_nxt = 1'b1;
            end
         end else begin
            state_nxt = IDLE;
            ready_nxt = 1'b1;
            done_nxt  = 1'b1;
         end
      end
   end

   seq_shift_out #(
      .W(SH_W)
   ) u_shift (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load),
      .shift(shift),
      .din  (frame_word),
      .sout (a_out)
   );

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen; follows SEQ_GEN_PARITY_EN for frame length.
module tb_seq_pattern_gen;
   import seq_pkg::*;

   localparam int PAT_W = PAT_W_DEF;
   localparam int REP_W = REP_W_DEF;
   localparam int GAP_W = GAP_W_DEF;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             use_default;
   logic [PAT_W-1:0] pat_in;
   logic [REP_W-1:0] rep_in;
   logic [GAP_W-1:0] gap_in;
   logic             ready;
   logic             a_out;
   logic             a_valid;
   logic             done;

   int               n_vec = 0;
   int               n_err = 0;
   int               n_match = 0;
   int               m0;
   int               n_done;
   logic [7:0]       hist = 8'hFF;

   seq_pattern_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .use_default(use_default),
      .pat_in     (pat_in),
      .rep_in     (rep_in),
      .gap_in     (gap_in),
      .ready      (ready),
      .a_out      (a_out),
      .a_valid    (a_valid),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream detector stand-in: counts 01110001 over contiguous valid bits.
   always @(posedge clk) begin
      if (!rst_n || !a_valid) begin
         hist <= 8'hFF;
      end else begin
         hist <= {hist[6:0], a_out};
         if ({hist[6:0], a_out} == 8'b01110001) n_match <= n_match + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic chk_frame(input logic [7:0] w);
      for (int i = PAT_W - 1; i >= 0; i--) begin
         tick;
         chk("bit", 32'(a_out), 32'(w[i]));
         chk("bit_valid", 32'(a_valid), 32'd1);
         chk("bit_ready", 32'(ready), 32'd0);
      end
`ifdef SEQ_GEN_PARITY_EN
      tick;
      chk("parity", 32'(a_out), 32'(~^w));
      chk("parity_valid", 32'(a_valid), 32'd1);
`endif
   endtask

   task automatic chk_gap;
      tick;
      chk("gap_line", 32'(a_out), 32'd1);
      chk("gap_valid", 32'(a_valid), 32'd0);
      chk("gap_ready", 32'(ready), 32'd0);
   endtask

   task automatic chk_done;
      tick;
      chk("done", 32'(done), 32'd1);
      chk("done_ready", 32'(ready), 32'd1);
      chk("done_valid", 32'(a_valid), 32'd0);
      chk("done_line", 32'(a_out), 32'd1);
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      use_default = 1'b0;
      pat_in      = '0;
      rep_in      = '0;
      gap_in      = '0;

      repeat (3) tick;
      rst_n = 1'b1;
      tick;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_line", 32'(a_out), 32'd1);
      chk("rst_valid", 32'(a_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      // Default pattern, single frame; pat_in must be ignored.
      use_default = 1'b1;
      pat_in      = 8'hFF;
      m0          = n_match;
      pulse_start;
      chk_frame(8'b01110001);
      chk_done;
      tick;
      chk("done_once", 32'(done), 32'd0);
      chk("match_once", 32'(n_match - m0), 32'd1);

      // A5 twice with a two-cycle gap; inputs scrambled mid-transfer.
      use_default = 1'b0;
      pat_in      = 8'hA5;
      rep_in      = 4'd1;
      gap_in      = 4'd2;
      pulse_start;
      pat_in      = 8'h00;
      rep_in      = 4'd0;
      gap_in      = 4'd0;
      chk_frame(8'hA5);
      chk_gap;
      chk_gap;
      chk_frame(8'hA5);
      chk_done;
      tick;

      // Three frames back-to-back with start held; restart in the done cycle.
      pat_in = 8'h71;
      rep_in = 4'd2;
      gap_in = 4'd0;
      start  = 1'b1;
      @(posedge clk);
      chk_frame(8'h71);
      chk_frame(8'h71);
      chk_frame(8'h71);
      chk_done;
      tick;
      chk("restart_valid", 32'(a_valid), 32'd1);
      chk("restart_msb", 32'(a_out), 32'd0);
      chk("restart_ready", 32'(ready), 32'd0);
      chk("restart_done", 32'(done), 32'd0);
      start = 1'b0;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;

      // Reset during bit 4 aborts the frame without done.
      pat_in = 8'hA5;
      rep_in = 4'd3;
      pulse_start;
      repeat (4) tick;
      chk("bit4", 32'(a_out), 32'd0);
      rst_n = 1'b0;
      tick;
      chk("abort_line", 32'(a_out), 32'd1);
      chk("abort_valid", 32'(a_valid), 32'd0);
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      rst_n  = 1'b1;
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (done) n_done++;
      end
      chk("abort_no_done", 32'(n_done), 32'd0);
      chk("abort_idle", 32'(ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
